// File: rtl/hub75_scan_driver.sv
// HUB75 LED panel scan driver: shifts one row pair of colour data per row period,
// latches it, then lights it for a fixed display time before moving to the next row.
module hub75_scan_driver #(
    parameter int COLS     = 64,
    parameter int ROW_BITS = 5,
    parameter int DIV      = 2,
    parameter int OE_ON    = 256
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          enable,
    output logic [ROW_BITS+((COLS>1)?$clog2(COLS):1)-1:0] fb_addr,
    input  logic [5:0]                                    fb_data,
    output logic                                          H75_R1,
    output logic                                          H75_G1,
    output logic                                          H75_B1,
    output logic                                          H75_R2,
    output logic                                          H75_G2,
    output logic                                          H75_B2,
    output logic                                          H75_A,
    output logic                                          H75_B,
    output logic                                          H75_C,
    output logic                                          H75_D,
    output logic                                          H75_E,
    output logic                                          H75_Clk,
    output logic                                          H75_Lat,
    output logic                                          H75_OE,
    output logic                                          frame_start
);

    localparam int COL_BITS = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CNT_MAX  = (2 * DIV > OE_ON) ? 2 * DIV : OE_ON;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]    SHIFT_LAST = CNT_W'(2 * DIV - 1);
    localparam logic [CNT_W-1:0]    RISE_PREV  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]    CAPTURE_AT = CNT_W'(1);
    localparam logic [CNT_W-1:0]    LATCH_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]    DISP_LAST  = CNT_W'(OE_ON - 1);
    localparam logic [COL_BITS-1:0] COL_LAST   = COL_BITS'(COLS - 1);
    localparam logic [COL_BITS-1:0] COL_ZERO   = '0;

    typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY} state_t;

    state_t                       state_reg;
    logic [CNT_W-1:0]             cnt_reg;
    logic [COL_BITS-1:0]          col_reg;
    logic [ROW_BITS-1:0]          row_reg;
    logic [ROW_BITS+COL_BITS-1:0] fb_addr_reg;
    logic [5:0]                   rgb_reg;
    logic [ROW_BITS-1:0]          row_addr_reg;
    logic                         h75_clk_reg;
    logic                         lat_reg;
    logic                         oe_reg;
    logic                         frame_start_reg;

    logic [ROW_BITS-1:0] row_inc;
    logic [COL_BITS-1:0] col_inc;
    logic [4:0]          row_pins;

    assign row_inc = row_reg + 1'b1;
    assign col_inc = col_reg + 1'b1;

    // Every output is a register loaded one clk ahead, so each state's values
    // are set on the transition into it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            col_reg         <= '0;
            row_reg         <= '0;
            fb_addr_reg     <= '0;
            rgb_reg         <= '0;
            row_addr_reg    <= '0;
            h75_clk_reg     <= 1'b0;
            lat_reg         <= 1'b0;
            oe_reg          <= 1'b1;
            frame_start_reg <= 1'b0;
        end else begin
            frame_start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    h75_clk_reg <= 1'b0;
                    lat_reg     <= 1'b0;
                    oe_reg      <= 1'b1;
                    if (enable) begin
                        state_reg   <= SHIFT;
                        cnt_reg     <= '0;
                        col_reg     <= '0;
                        fb_addr_reg <= {row_reg, COL_ZERO};
                    end
                end
                SHIFT: begin
                    // fb_data answers the address issued on clk 0, so it is valid on clk 1
                    if (cnt_reg == CAPTURE_AT) begin
                        rgb_reg <= fb_data;
                    end
                    if (cnt_reg == SHIFT_LAST) begin
                        cnt_reg     <= '0;
                        h75_clk_reg <= 1'b0;
                        if (col_reg == COL_LAST) begin
                            state_reg <= BLANK;
                        end else begin
                            col_reg     <= col_inc;
                            fb_addr_reg <= {row_reg, col_inc};
                        end
                    end else begin
                        cnt_reg     <= cnt_reg + 1'b1;
                        h75_clk_reg <= (cnt_reg >= RISE_PREV);
                    end
                end
                BLANK: begin
                    state_reg       <= LATCH;
                    cnt_reg         <= '0;
                    lat_reg         <= 1'b1;
                    row_addr_reg    <= row_reg;
                    frame_start_reg <= (row_reg == '0);
                end
                LATCH: begin
                    if (cnt_reg == LATCH_LAST) begin
                        state_reg <= DISPLAY;
                        cnt_reg   <= '0;
                        lat_reg   <= 1'b0;
                        oe_reg    <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DISPLAY: begin
                    if (cnt_reg == DISP_LAST) begin
                        oe_reg  <= 1'b1;
                        cnt_reg <= '0;
                        row_reg <= row_inc;
                        if (enable) begin
                            state_reg   <= SHIFT;
                            col_reg     <= '0;
                            fb_addr_reg <= {row_inc, COL_ZERO};
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    oe_reg    <= 1'b1;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < 5; gi++) begin : g_row_pin
        if (gi < ROW_BITS) begin : g_used
            assign row_pins[gi] = row_addr_reg[gi];
        end else begin : g_tied
            assign row_pins[gi] = 1'b0;
        end
    end

    assign fb_addr = fb_addr_reg;
    assign {H75_R1, H75_G1, H75_B1, H75_R2, H75_G2, H75_B2} = rgb_reg;
    assign {H75_E, H75_D, H75_C, H75_B, H75_A} = row_pins;
    assign H75_Clk     = h75_clk_reg;
    assign H75_Lat     = lat_reg;
    assign H75_OE      = oe_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Bench for hub75_scan_driver: random framebuffer contents, panel-level reference
// model of row/column/latch/display timing, plus a small-geometry instance.
module tb_hub75_scan_driver;

    localparam int COLS       = 64;
    localparam int ROW_BITS   = 5;
    localparam int DIV        = 2;
    localparam int OE_ON      = 256;
    localparam int CB         = 6;
    localparam int AW         = ROW_BITS + CB;
    localparam int ROWS       = 1 << ROW_BITS;
    localparam int ROW_PERIOD = COLS * 2 * DIV + 1 + DIV + OE_ON;

    localparam int S_COLS     = 4;
    localparam int S_ROW_BITS = 2;
    localparam int S_DIV      = 3;
    localparam int S_OE_ON    = 1;
    localparam int S_AW       = 4;
    localparam int S_PERIOD   = S_COLS * 2 * S_DIV + 1 + S_DIV + S_OE_ON;

    logic clk = 1'b0;
    logic rst_n, enable;
    logic [AW-1:0] fb_addr;
    logic [5:0] fb_data = '0;
    logic r1, g1, b1, r2, g2, b2, pa, pb, pc, pd, pe, h_clk, lat, oe, frame_start;

    logic rst_n_s, enable_s;
    logic [S_AW-1:0] fb_addr_s;
    logic [5:0] fb_data_s = '0;
    logic sr1, sg1, sb1, sr2, sg2, sb2, spa, spb, spc, spd, spe, s_clk, s_lat, s_oe, s_fs;

    logic [5:0] mem   [0:(1<<AW)-1];
    logic [5:0] mem_s [0:(1<<S_AW)-1];

    wire [5:0] colours   = {r1, g1, b1, r2, g2, b2};
    wire [4:0] row_pins  = {pe, pd, pc, pb, pa};
    wire [5:0] colours_s = {sr1, sg1, sb1, sr2, sg2, sb2};
    wire [4:0] row_pins_s = {spe, spd, spc, spb, spa};

    int checks = 0;
    int errors = 0;

    hub75_scan_driver #(.COLS(COLS), .ROW_BITS(ROW_BITS), .DIV(DIV), .OE_ON(OE_ON)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fb_addr(fb_addr), .fb_data(fb_data),
        .H75_R1(r1), .H75_G1(g1), .H75_B1(b1), .H75_R2(r2), .H75_G2(g2), .H75_B2(b2),
        .H75_A(pa), .H75_B(pb), .H75_C(pc), .H75_D(pd), .H75_E(pe),
        .H75_Clk(h_clk), .H75_Lat(lat), .H75_OE(oe), .frame_start(frame_start)
    );

    hub75_scan_driver #(.COLS(S_COLS), .ROW_BITS(S_ROW_BITS), .DIV(S_DIV), .OE_ON(S_OE_ON)) dut_small (
        .clk(clk), .rst_n(rst_n_s), .enable(enable_s), .fb_addr(fb_addr_s), .fb_data(fb_data_s),
        .H75_R1(sr1), .H75_G1(sg1), .H75_B1(sb1), .H75_R2(sr2), .H75_G2(sg2), .H75_B2(sb2),
        .H75_A(spa), .H75_B(spb), .H75_C(spc), .H75_D(spd), .H75_E(spe),
        .H75_Clk(s_clk), .H75_Lat(s_lat), .H75_OE(s_oe), .frame_start(s_fs)
    );

    always #5 clk = ~clk;

    // Framebuffer RAM with one clk read latency.
    always @(posedge clk) begin
        fb_data   <= mem[fb_addr];
        fb_data_s <= mem_s[fb_addr_s];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model of the default panel: which row is on the wires and which
    // column each shift-clock rise carries.
    int m_row = 0, m_rises = 0, m_lat_len = 0, m_oe_len = 0;
    int colour_errs = 0, row_errs = 0, cnt_errs = 0, lat_errs = 0, oe_errs = 0, fs_errs = 0, viol = 0;
    int total_rises = 0, lat_count = 0, last_start = 0, prev_start = 0;
    int fs_time_q[$];
    logic p_clk = 1'b0, p_lat = 1'b0, p_oe = 1'b1;
    logic [4:0] p_addr = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_row = 0; m_rises = 0; m_lat_len = 0; m_oe_len = 0;
        end else begin
            if (h_clk && !p_clk) begin
                if (m_rises == 0) begin
                    prev_start = last_start;
                    last_start = cyc;
                end
                if (m_rises >= COLS || colours !== mem[{m_row[ROW_BITS-1:0], m_rises[CB-1:0]}])
                    colour_errs++;
                m_rises++;
                total_rises++;
            end
            if (lat) m_lat_len++;
            if (frame_start !== (lat && !p_lat && m_row == 0)) fs_errs++;
            if (frame_start) fs_time_q.push_back(cyc);
            if (lat && !p_lat) begin
                lat_count++;
                if (row_pins !== m_row[4:0]) row_errs++;
                if (m_rises != COLS) cnt_errs++;
                m_rises = 0;
            end
            if (!lat && p_lat) begin
                if (m_lat_len != DIV) lat_errs++;
                m_lat_len = 0;
            end
            if (!oe) m_oe_len++;
            if (oe && !p_oe) begin
                if (m_oe_len != OE_ON) oe_errs++;
                m_oe_len = 0;
                m_row = (m_row + 1) % ROWS;
            end
            if (!oe && (h_clk || lat)) viol++;
            if (!oe && !p_oe && row_pins !== p_addr) viol++;
        end
        p_clk = h_clk; p_lat = lat; p_oe = oe; p_addr = row_pins;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < (1 << AW); i++) mem[i] = 6'($urandom);
        for (int i = 0; i < (1 << S_AW); i++) mem_s[i] = 6'($urandom);
        rst_n = 1'b0; enable = 1'b0; rst_n_s = 1'b0; enable_s = 1'b0;
        repeat (4) step();
        checks++; if (fb_addr !== '0) begin errors++; $display("FAIL reset_fb_addr: got %0h exp 0", fb_addr); end
        checks++; if (colours !== '0) begin errors++; $display("FAIL reset_colours: got %0h exp 0", colours); end
        checks++; if (row_pins !== '0) begin errors++; $display("FAIL reset_row_pins: got %0h exp 0", row_pins); end
        checks++; if ({h_clk, lat, oe, frame_start} !== 4'b0010) begin
            errors++; $display("FAIL reset_ctrl: got clk/lat/oe/fs=%b exp 0010", {h_clk, lat, oe, frame_start});
        end
        rst_n = 1'b1;
        repeat (20) step();
        checks++; if (total_rises !== 0 || oe !== 1'b1) begin
            errors++; $display("FAIL idle_no_enable: got rises=%0d oe=%b exp rises=0 oe=1", total_rises, oe);
        end
    endtask

    task automatic test_first_row();
        int n;
        enable = 1'b1;
        step();
        checks++; if (fb_addr !== '0 || h_clk !== 1'b0 || oe !== 1'b1) begin
            errors++; $display("FAIL first_shift_clk0: got addr=%0h clk=%b oe=%b exp addr=0 clk=0 oe=1", fb_addr, h_clk, oe);
        end
        repeat (2 * DIV) step();
        checks++; if (fb_addr !== AW'(1)) begin errors++; $display("FAIL col1_addr: got %0h exp 1", fb_addr); end
        n = 0;
        while (lat_count < 1 && n < ROW_PERIOD) begin step(); n++; end
        checks++; if (lat_count != 1 || total_rises != COLS) begin
            errors++; $display("FAIL row0_shift: got lat=%0d rises=%0d exp lat=1 rises=%0d", lat_count, total_rises, COLS);
        end
        checks++; if (fs_time_q.size() != 1) begin errors++; $display("FAIL row0_frame_start: got %0d pulses exp 1", fs_time_q.size()); end
        n = 0;
        while (total_rises <= COLS && n < ROW_PERIOD) begin step(); n++; end
        checks++; if (last_start - prev_start != ROW_PERIOD) begin
            errors++; $display("FAIL row_period: got %0d exp %0d", last_start - prev_start, ROW_PERIOD);
        end
        checks++; if (oe_errs != 0 || lat_errs != 0) begin
            errors++; $display("FAIL row0_lat_oe_len: got oe_errs=%0d lat_errs=%0d exp 0 0", oe_errs, lat_errs);
        end
    endtask

    task automatic test_frame_wrap();
        int n = 0;
        while (fs_time_q.size() < 2 && n < ROWS * ROW_PERIOD + 100) begin step(); n++; end
        checks++; if (fs_time_q.size() < 2) begin
            errors++; $display("FAIL frame_wrap_timeout: got %0d pulses exp 2", fs_time_q.size());
        end else if (fs_time_q[1] - fs_time_q[0] != ROWS * ROW_PERIOD) begin
            errors++; $display("FAIL frame_period: got %0d exp %0d", fs_time_q[1] - fs_time_q[0], ROWS * ROW_PERIOD);
        end
        checks++; if (row_errs != 0) begin errors++; $display("FAIL row_sequence: got %0d bad rows exp 0", row_errs); end
    endtask

    task automatic test_enable_drop();
        int n = 0, lc, r0;
        while (!(m_row == 3 && m_rises == 11) && n < 4 * ROW_PERIOD) begin step(); n++; end
        checks++; if (!(m_row == 3 && m_rises == 11)) begin
            errors++; $display("FAIL drop_wait_timeout: got row=%0d rises=%0d exp 3 11", m_row, m_rises);
        end
        enable = 1'b0;
        lc = lat_count;
        n = 0;
        while (m_row != 4 && n < 2 * ROW_PERIOD) begin step(); n++; end
        checks++; if (lat_count != lc + 1 || m_row != 4) begin
            errors++; $display("FAIL row3_completes: got lat=%0d row=%0d exp lat=%0d row=4", lat_count, m_row, lc + 1);
        end
        r0 = total_rises;
        repeat (200) step();
        checks++; if (total_rises != r0 || oe !== 1'b1 || lat !== 1'b0) begin
            errors++; $display("FAIL idle_after_drop: got rises+%0d oe=%b lat=%b exp +0 1 0", total_rises - r0, oe, lat);
        end
        enable = 1'b1;
        n = 0;
        while (lat_count < lc + 2 && n < 2 * ROW_PERIOD) begin step(); n++; end
        checks++; if (row_pins !== 5'd4) begin errors++; $display("FAIL resume_row: got %0d exp 4", row_pins); end
    endtask

    task automatic test_reset_mid_display();
        int n = 0, fsn;
        while (!(m_row == 7 && m_oe_len == 100) && n < 5 * ROW_PERIOD) begin step(); n++; end
        checks++; if (oe !== 1'b0 || row_pins !== 5'd7) begin
            errors++; $display("FAIL row7_display: got oe=%b row=%0d exp 0 7", oe, row_pins);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (oe !== 1'b1 || row_pins !== '0 || {h_clk, lat} !== 2'b00 || fb_addr !== '0) begin
            errors++; $display("FAIL async_reset: got oe=%b row=%0d clk/lat=%b addr=%0h exp 1 0 00 0", oe, row_pins, {h_clk, lat}, fb_addr);
        end
        repeat (3) step();
        fsn = fs_time_q.size();
        rst_n = 1'b1;
        repeat (1 + 2 * DIV) step();
        checks++; if (fb_addr !== AW'(1)) begin errors++; $display("FAIL restart_addr: got %0h exp 1", fb_addr); end
        n = 0;
        while (fs_time_q.size() == fsn && n < ROW_PERIOD) begin step(); n++; end
        checks++; if (fs_time_q.size() != fsn + 1 || row_pins !== '0) begin
            errors++; $display("FAIL restart_row0: got pulses=%0d row=%0d exp %0d 0", fs_time_q.size() - fsn, row_pins, 1);
        end
    endtask

    task automatic test_small_config();
        int hi_len = 0, lo_len = 0, oe_len = 0, rises = 0, row = 0, last_lat = -1;
        int hi_bad = 0, lo_bad = 0, oe_bad = 0, per_bad = 0, col_bad = 0, addr_bad = 0, lat_seen = 0;
        logic pck = 1'b0, plt = 1'b0, poe = 1'b1;
        rst_n_s = 1'b1; enable_s = 1'b1;
        for (int i = 0; i < 5 * S_PERIOD; i++) begin
            step();
            if (s_clk) hi_len++; else lo_len++;
            if (s_clk && !pck) begin
                if (rises > 0 && lo_len != S_DIV) lo_bad++;
                if (rises >= S_COLS || colours_s !== mem_s[{row[1:0], rises[1:0]}]) col_bad++;
                rises++;
                lo_len = 0;
            end
            if (!s_clk && pck) begin
                if (hi_len != S_DIV) hi_bad++;
                hi_len = 0;
            end
            if (s_lat && !plt) begin
                if (last_lat >= 0 && i - last_lat != S_PERIOD) per_bad++;
                if (row_pins_s !== {3'b000, row[1:0]}) addr_bad++;
                last_lat = i;
                lat_seen++;
                rises = 0;
            end
            if (!s_oe) oe_len++;
            if (s_oe && !poe) begin
                if (oe_len != S_OE_ON) oe_bad++;
                oe_len = 0;
                row = (row + 1) % 4;
            end
            pck = s_clk; plt = s_lat; poe = s_oe;
        end
        checks++; if (hi_bad != 0 || lo_bad != 0) begin
            errors++; $display("FAIL small_clk_halves: got bad high=%0d low=%0d exp 0 0", hi_bad, lo_bad);
        end
        checks++; if (oe_bad != 0) begin errors++; $display("FAIL small_oe_len: got %0d bad exp 0", oe_bad); end
        checks++; if (per_bad != 0 || lat_seen < 4) begin
            errors++; $display("FAIL small_row_period: got bad=%0d latches=%0d exp 0 >=4", per_bad, lat_seen);
        end
        checks++; if (col_bad != 0 || addr_bad != 0) begin
            errors++; $display("FAIL small_data: got colour_bad=%0d addr_bad=%0d exp 0 0", col_bad, addr_bad);
        end
    endtask

    task automatic test_final();
        checks++; if (viol != 0) begin errors++; $display("FAIL oe_protocol: got %0d violations exp 0", viol); end
        checks++; if (colour_errs != 0) begin errors++; $display("FAIL colours: got %0d bad exp 0", colour_errs); end
        checks++; if (cnt_errs != 0) begin errors++; $display("FAIL clk_rises_per_row: got %0d bad rows exp 0", cnt_errs); end
        checks++; if (row_errs != 0) begin errors++; $display("FAIL row_addr: got %0d bad exp 0", row_errs); end
        checks++; if (lat_errs != 0 || oe_errs != 0) begin
            errors++; $display("FAIL lat_oe_len: got lat=%0d oe=%0d bad exp 0 0", lat_errs, oe_errs);
        end
        checks++; if (fs_errs != 0) begin errors++; $display("FAIL frame_start: got %0d bad exp 0", fs_errs); end
    endtask

    initial begin
        test_reset();
        test_first_row();
        test_frame_wrap();
        test_enable_drop();
        test_reset_mid_display();
        test_small_config();
        test_final();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
